// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive peripheral.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_t;

  localparam int CTRL_RX_VALID  = 0;
  localparam int CTRL_OVERRUN   = 1;
  localparam int CTRL_FRAME_ERR = 2;

  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 9600;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deframer: input synchronizer, baud counter and receive FSM.
//
// state     | meaning
// IDLE      | line high, waiting for a falling edge
// START     | counting to mid start bit to reject glitches
// DATA      | sampling 8 data bits LSB first, one per bit time
// STOP      | counting to mid stop bit, then judging the frame
// WAIT_IDLE | holding off until the line is high again
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           rx_meta, rx_s;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d        = '0;
          byte_valid_o = rx_s;
          frame_err_o  = !rx_s;
          state_d      = WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/peri_uart_rx.sv
// Memory-mapped UART receiver: data register plus sticky status flags that
// software clears by writing 0 to the corresponding bit.
module peri_uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        uart_rx_i,
  input  logic [31:0] data_i,
  input  logic        we_ctrl_uart_i,
  output logic [31:0] data_o,
  output logic [31:0] ctrl_o
);

  logic [7:0] rx_byte, data_q;
  logic       rx_byte_valid, rx_frame_err;
  logic [2:0] ctrl_q, ctrl_d;
  logic       unused_data;

  assign unused_data = ^data_i[31:3];

  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_core (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rx_i        (uart_rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_byte_valid),
    .frame_err_o (rx_frame_err)
  );

  // Hardware sets are applied after the software mask so a set always wins.
  always_comb begin
    ctrl_d = ctrl_q;
    if (we_ctrl_uart_i) ctrl_d = ctrl_q & data_i[2:0];
    if (rx_byte_valid) begin
      ctrl_d[CTRL_RX_VALID] = 1'b1;
      if (ctrl_q[CTRL_RX_VALID]) ctrl_d[CTRL_OVERRUN] = 1'b1;
    end
    if (rx_frame_err) ctrl_d[CTRL_FRAME_ERR] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      if (rx_byte_valid) data_q <= rx_byte;
    end
  end

  assign data_o = {24'b0, data_q};
  assign ctrl_o = {29'b0, ctrl_q};

endmodule

// File: tb/tb_peri_uart_rx.sv
// Directed and randomized frames against a frame-level flag/data model.
module tb_peri_uart_rx;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        uart_rx_i = 1'b1;
  logic [31:0] data_i = '0;
  logic        we_ctrl_uart_i = 1'b0;
  logic [31:0] data_o, ctrl_o;

  int checks = 0;
  int errors = 0;

  // Reference model: newest byte and the three sticky flags.
  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_ferr;

  peri_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .uart_rx_i     (uart_rx_i),
    .data_i        (data_i),
    .we_ctrl_uart_i(we_ctrl_uart_i),
    .data_o        (data_o),
    .ctrl_o        (ctrl_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_ctrl();
    return {29'b0, m_ferr, m_ovr, m_valid};
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      wait_clks(CPB);
    end
    uart_rx_i = stop;
    wait_clks(CPB);
    uart_rx_i = 1'b1;
    model_frame(b, stop);
  endtask

  task automatic ctrl_write(input logic [2:0] mask);
    data_i         = {29'h0, mask};
    we_ctrl_uart_i = 1'b1;
    wait_clks(1);
    we_ctrl_uart_i = 1'b0;
    data_i         = '0;
    m_valid &= mask[0];
    m_ovr   &= mask[1];
    m_ferr  &= mask[2];
  endtask

  task automatic check_model(input string tag);
    check({tag, "_data"}, data_o, {24'b0, m_data});
    check({tag, "_ctrl"}, ctrl_o, m_ctrl());
  endtask

  initial begin
    logic [7:0] b;
    logic       st;
    logic [2:0] mask;
    m_data = '0; m_valid = 0; m_ovr = 0; m_ferr = 0;

    wait_clks(3);
    reset_i = 1'b0;
    wait_clks(20 * CPB);
    check("reset_data", data_o, 32'h0);
    check("reset_ctrl", ctrl_o, 32'h0);

    send_frame(8'h55, 1'b1);
    wait_clks(2);
    check("rx55_data", data_o, 32'h55);
    check("rx55_ctrl", ctrl_o, 32'h1);
    ctrl_write(3'b000);

    wait_clks(2 * CPB);
    send_frame(8'hA3, 1'b1);
    wait_clks(2);
    check("rxA3_before_clr", ctrl_o, 32'h1);
    ctrl_write(3'b000);
    check("rxA3_after_clr", ctrl_o, 32'h0);
    check("rxA3_data_kept", data_o, 32'hA3);

    wait_clks(2 * CPB);
    send_frame(8'h12, 1'b1);
    wait_clks(2 * CPB);
    send_frame(8'h34, 1'b1);
    wait_clks(2);
    check("ovr_data", data_o, 32'h34);
    check("ovr_ctrl", ctrl_o, 32'h3);
    ctrl_write(3'b000);

    // Bad stop bit followed by a long break.
    wait_clks(2 * CPB);
    send_frame(8'h7E, 1'b0);
    uart_rx_i = 1'b0;
    wait_clks(2);
    check("ferr_ctrl", ctrl_o, 32'h4);
    check("ferr_data", data_o, 32'h34);
    ctrl_write(3'b000);
    wait_clks(3 * CPB + 10 * CPB);
    check("break_no_retrigger", ctrl_o, 32'h0);
    uart_rx_i = 1'b1;
    wait_clks(2 * CPB);
    send_frame(8'hC3, 1'b1);
    wait_clks(2);
    check_model("after_break");
    ctrl_write(3'b000);

    // Short glitch on an idle line.
    wait_clks(2 * CPB);
    uart_rx_i = 1'b0;
    wait_clks($urandom_range(2, CPB / 2 - 4));
    uart_rx_i = 1'b1;
    wait_clks(12 * CPB);
    check("glitch_ctrl", ctrl_o, 32'h0);
    check("glitch_data", data_o, 32'hC3);

    // Randomized frames with optional partial clears.
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      st   = ($urandom_range(0, 3) != 0);
      mask = 3'($urandom);
      wait_clks(2 * CPB);
      send_frame(b, st);
      wait_clks(2);
      check_model($sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        ctrl_write(mask);
        check($sformatf("rand%0d_clr", n), ctrl_o, m_ctrl());
      end
    end

    // Reset in the middle of the 4th data bit of 0xC5.
    wait_clks(2 * CPB);
    b = 8'hC5;
    uart_rx_i = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx_i = b[i];
      wait_clks(CPB);
    end
    uart_rx_i = b[3];
    wait_clks(CPB / 2);
    reset_i = 1'b1;
    wait_clks(2);
    reset_i = 1'b0;
    check("midreset_data", data_o, 32'h0);
    check("midreset_ctrl", ctrl_o, 32'h0);
    wait_clks(CPB - CPB / 2 - 2);
    for (int i = 4; i < 8; i++) begin
      uart_rx_i = b[i];
      wait_clks(CPB);
    end
    uart_rx_i = 1'b1;
    wait_clks(12 * CPB);
    m_valid = 0; m_ovr = 0; m_ferr = 0;
    ctrl_write(3'b000);
    check("postreset_clr", ctrl_o, 32'h0);
    wait_clks(2 * CPB);
    send_frame(8'h5A, 1'b1);
    wait_clks(2);
    check("postreset_data", data_o, 32'h5A);
    check("postreset_ctrl", ctrl_o, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
